slot_reels: RTL and testbench

Parametrised multi-reel "slot machine" display controller. Drives NUM_REELS seven-segment digits. In idle, every digit counts down freely at the roll rate. A spin request runs a fixed spin period, then locks each reel onto its externally supplied target digit in left-to-right staggered order. The result is held for a fixed period, then free rolling resumes. It sits between the random-digit sources and the segment pins, and replaces the per-digit divider/iterator/one-shot-clock arrangement with a single-clock, tick-enabled FSM.

---
 rtl/slot_pkg.sv | 34 +++
 rtl/slot_reels_if.sv | 22 ++
 rtl/slot_reel.sv | 43 ++++
 rtl/slot_reels.sv | 140 ++++++++++++++
 tb/tb_slot_reels.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slot_pkg.sv
// Shared types, widths and the seven-segment table for the slot reel display.
package slot_pkg;

    localparam int unsigned DIGIT_W = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned CNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE,
        SPIN,
        SETTLE,
        HOLD
    } state_t;

    // gfedcba, active-high, indexed by digit 0..9
    localparam logic [SEG_W-1:0] SEG_LUT [10] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Segment pattern for a digit; non-decimal codes blank the display.
    function automatic logic [SEG_W-1:0] seg_of(input logic [DIGIT_W-1:0] d);
        logic [SEG_W-1:0] s;
        s = '0;
        if (d <= DIGIT_W'(9)) s = SEG_LUT[d];
        return s;
    endfunction

    // Target codes 10..15 cannot be reached by a reel, so map them to 0.
    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_W'(9)) ? '0 : d;
    endfunction

endpackage

// File: rtl/slot_reels_if.sv
// Button/target inputs and display/status outputs of the reel controller.
interface slot_reels_if #(
    parameter int unsigned NUM_REELS = 4
);
    logic                                   spin;
    logic [slot_pkg::DIGIT_W*NUM_REELS-1:0] target;
    logic [slot_pkg::DIGIT_W*NUM_REELS-1:0] digit;
    logic [slot_pkg::SEG_W*NUM_REELS-1:0]   seg;
    logic [NUM_REELS-1:0]                   locked;
    logic                                   busy;
    logic                                   result_valid;

    modport master (
        output spin, target,
        input  digit, seg, locked, busy, result_valid
    );

    modport slave (
        input  spin, target,
        output digit, seg, locked, busy, result_valid
    );
endinterface

// File: rtl/slot_reel.sv
// One reel: down-counting digit, lock flag and the lock-on-target compare.
module slot_reel
    import slot_pkg::*;
#(
    parameter int unsigned IDX           = 0,
    parameter int unsigned STAGGER_TICKS = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               roll_en,
    input  logic               settle,
    input  logic               clear,
    input  logic [CNT_W-1:0]   tick_cnt,
    input  logic [DIGIT_W-1:0] tgt,
    output logic [DIGIT_W-1:0] digit,
    output logic               locked,
    output logic               lock_next_c
);

    localparam int unsigned ELIG = IDX * STAGGER_TICKS;

    logic eligible_c;
    logic lock_hit_c;

    // tick_cnt >= ELIG, written as +1 > ELIG so reel 0 does not fold to a constant
    assign eligible_c  = ({1'b0, tick_cnt} + (CNT_W+1)'(1)) > (CNT_W+1)'(ELIG);
    assign lock_hit_c  = settle & tick & ~locked & eligible_c & (digit == tgt);
    assign lock_next_c = locked | lock_hit_c;

    // Digit rolls 9..0 on each tick unless locked, locking now, or frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit  <= DIGIT_W'(9);
            locked <= 1'b0;
        end else begin
            locked <= clear ? 1'b0 : lock_next_c;
            if (tick && roll_en && !locked && !lock_hit_c)
                digit <= (digit == '0) ? DIGIT_W'(9) : digit - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/slot_reels.sv
// Multi-reel slot display: prescaler, spin synchroniser, sequencing FSM and reels.
module slot_reels
    import slot_pkg::*;
#(
    parameter int unsigned NUM_REELS     = 4,
    parameter int unsigned TICK_DIV      = 70,
    parameter int unsigned SPIN_TICKS    = 20,
    parameter int unsigned HOLD_TICKS    = 50,
    parameter int unsigned STAGGER_TICKS = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    slot_reels_if.slave  bus
);

    localparam int unsigned PRESC_W = $clog2(TICK_DIV);

    logic [PRESC_W-1:0]           presc_q;
    logic                         tick_c;
    logic [2:0]                   sync_q;
    logic                         spin_edge_c;
    state_t                       state_q, state_n;
    logic [CNT_W-1:0]             cnt_q, cnt_n;
    logic                         latch_c;
    logic [DIGIT_W*NUM_REELS-1:0] tgt_q;
    logic [NUM_REELS-1:0]         lock_next_c;
    logic                         busy_q, rv_q;

    assign tick_c      = (presc_q == PRESC_W'(TICK_DIV - 1));
    assign spin_edge_c = sync_q[1] & ~sync_q[2];

    // Free-running roll-rate prescaler.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      presc_q <= '0;
        else if (tick_c) presc_q <= '0;
        else             presc_q <= presc_q + PRESC_W'(1);
    end

    // Two-flop synchroniser plus the previous-value flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[1:0], bus.spin};
    end

    // Next state, phase tick counter and target latch strobe.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        latch_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (spin_edge_c) begin
                    state_n = SPIN;
                    cnt_n   = '0;
                end
            end
            SPIN: begin
                if (tick_c) begin
                    if (cnt_q == CNT_W'(SPIN_TICKS - 1)) begin
                        state_n = SETTLE;
                        cnt_n   = '0;
                        latch_c = 1'b1;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            SETTLE: begin
                if (tick_c) begin
                    if (&lock_next_c) begin
                        state_n = HOLD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (tick_c) begin
                    if (cnt_q == CNT_W'(HOLD_TICKS - 1)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM state, counter and registered status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            busy_q  <= (state_n != IDLE);
            rv_q    <= (state_n == HOLD);
        end
    end

    // Capture targets as SETTLE begins so later input changes cannot move the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tgt_q <= '0;
        end else if (latch_c) begin
            for (int unsigned k = 0; k < NUM_REELS; k++)
                tgt_q[k*DIGIT_W +: DIGIT_W] <= clamp_digit(bus.target[k*DIGIT_W +: DIGIT_W]);
        end
    end

    for (genvar k = 0; k < NUM_REELS; k++) begin : g_reel
        slot_reel #(
            .IDX           (k),
            .STAGGER_TICKS (STAGGER_TICKS)
        ) u_reel (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (tick_c),
            .roll_en     (state_q != HOLD),
            .settle      (state_q == SETTLE),
            .clear       (state_n == IDLE),
            .tick_cnt    (cnt_q),
            .tgt         (tgt_q[k*DIGIT_W +: DIGIT_W]),
            .digit       (bus.digit[k*DIGIT_W +: DIGIT_W]),
            .locked      (bus.locked[k]),
            .lock_next_c (lock_next_c[k])
        );
        assign bus.seg[k*SEG_W +: SEG_W] = seg_of(bus.digit[k*DIGIT_W +: DIGIT_W]);
    end

    assign bus.busy         = busy_q;
    assign bus.result_valid = rv_q;

endmodule

// File: tb/tb_slot_reels.sv
// Bench for slot_reels: default 4-reel build plus a fast 6-reel, zero-stagger build.
module tb_slot_reels;

    localparam int NR [2] = '{4, 6};
    localparam int TD [2] = '{70, 3};
    localparam int SP [2] = '{20, 4};
    localparam int HD [2] = '{50, 5};
    localparam int ST [2] = '{5, 0};
    localparam logic [6:0] SEGT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam int P_IDLE = 0, P_SPIN = 1, P_SETTLE = 2, P_HOLD = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    bit   done = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    slot_reels_if #(.NUM_REELS(4)) bus0 ();
    slot_reels_if #(.NUM_REELS(6)) bus1 ();

    slot_reels #(.NUM_REELS(4), .TICK_DIV(70), .SPIN_TICKS(20), .HOLD_TICKS(50),
                 .STAGGER_TICKS(5)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    slot_reels #(.NUM_REELS(6), .TICK_DIV(3), .SPIN_TICKS(4), .HOLD_TICKS(5),
                 .STAGGER_TICKS(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Reference model state, one slot per DUT
    int m_presc [2], m_ph [2], m_cnt [2];
    int m_dig [2][8];
    bit m_lk [2][8];
    int m_tg [2][8];
    bit m_s1 [2], m_s2 [2], m_s3 [2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
            if (n_fail >= 200) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_presc[i] = 0; m_ph[i] = P_IDLE; m_cnt[i] = 0;
            m_s1[i] = 0; m_s2[i] = 0; m_s3[i] = 0;
            for (int k = 0; k < 8; k++) begin
                m_dig[i][k] = 9; m_lk[i][k] = 0; m_tg[i][k] = 0;
            end
        end
    endtask

    task automatic roll_all(input int i);
        for (int k = 0; k < NR[i]; k++) m_dig[i][k] = (m_dig[i][k] + 9) % 10;
    endtask

    task automatic model_step(input int i, input bit sp, input logic [31:0] tg);
        bit tick, edge_seen, all_lk;
        int v;
        tick      = (m_presc[i] == TD[i] - 1);
        edge_seen = m_s2[i] && !m_s3[i];
        m_s3[i] = m_s2[i]; m_s2[i] = m_s1[i]; m_s1[i] = sp;
        m_presc[i] = tick ? 0 : m_presc[i] + 1;
        case (m_ph[i])
            P_IDLE: begin
                if (tick) roll_all(i);
                if (edge_seen) begin m_ph[i] = P_SPIN; m_cnt[i] = 0; end
            end
            P_SPIN: if (tick) begin
                roll_all(i);
                if (m_cnt[i] == SP[i] - 1) begin
                    m_ph[i] = P_SETTLE; m_cnt[i] = 0;
                    for (int k = 0; k < 8; k++) begin
                        v = int'(tg[4*k +: 4]);
                        m_tg[i][k] = (v > 9) ? 0 : v;
                    end
                end else m_cnt[i]++;
            end
            P_SETTLE: if (tick) begin
                all_lk = 1;
                for (int k = 0; k < NR[i]; k++) begin
                    if (!m_lk[i][k]) begin
                        if (m_cnt[i] >= k * ST[i] && m_dig[i][k] == m_tg[i][k]) m_lk[i][k] = 1;
                        else m_dig[i][k] = (m_dig[i][k] + 9) % 10;
                    end
                    if (!m_lk[i][k]) all_lk = 0;
                end
                if (all_lk) begin m_ph[i] = P_HOLD; m_cnt[i] = 0; end
                else m_cnt[i]++;
            end
            default: if (tick) begin
                if (m_cnt[i] == HD[i] - 1) begin
                    m_ph[i] = P_IDLE; m_cnt[i] = 0;
                    for (int k = 0; k < 8; k++) m_lk[i][k] = 0;
                end else m_cnt[i]++;
            end
        endcase
    endtask

    // Model advances with the clock and resets asynchronously with the DUTs
    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else begin
                model_step(0, bus0.spin, 32'(bus0.target));
                model_step(1, bus1.spin, 32'(bus1.target));
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model
    initial begin
        logic [63:0] ed, es, el;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                ed = '0; es = '0; el = '0;
                for (int k = 0; k < NR[i]; k++) begin
                    ed[4*k +: 4] = 4'(m_dig[i][k]);
                    es[7*k +: 7] = SEGT[m_dig[i][k]];
                    el[k]        = m_lk[i][k];
                end
                if (i == 0) begin
                    chk("m0_digit",  64'(bus0.digit),  ed);
                    chk("m0_seg",    64'(bus0.seg),    es);
                    chk("m0_locked", 64'(bus0.locked), el);
                    chk("m0_busy",   64'(bus0.busy),   64'(m_ph[0] != P_IDLE));
                    chk("m0_rv",     64'(bus0.result_valid), 64'(m_ph[0] == P_HOLD));
                end else begin
                    chk("m1_digit",  64'(bus1.digit),  ed);
                    chk("m1_seg",    64'(bus1.seg),    es);
                    chk("m1_locked", 64'(bus1.locked), el);
                    chk("m1_busy",   64'(bus1.busy),   64'(m_ph[1] != P_IDLE));
                    chk("m1_rv",     64'(bus1.result_valid), 64'(m_ph[1] == P_HOLD));
                end
            end
        end
    end

    // Six-reel zero-stagger build: all reels settle within 10 ticks (30 clks)
    initial begin
        int win;
        win = 0;
        forever begin
            @(negedge clk);
            if (!rst_n || (bus1.locked == '0 && !bus1.result_valid)) win = 0;
            else if (!bus1.result_valid) win++;
            else if (win > 0) begin
                chk("settle_window6", 64'(win <= 30), 64'(1));
                win = 0;
            end
        end
    end

    // Random spin traffic on the six-reel build
    initial begin
        bus1.spin = 1'b0;
        bus1.target = '0;
        @(posedge rst_n);
        while (!done) begin
            repeat ($urandom_range(0, 20)) @(posedge clk);
            #1 bus1.target = 24'($urandom);
            bus1.spin = 1'b1;
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1 bus1.spin = 1'b0;
            repeat ($urandom_range(1, 6)) @(posedge clk);
        end
    end

    // Spin request from IDLE, checking the 3-clk edge-to-busy latency
    task automatic press0();
        @(posedge clk); #1 bus0.spin = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("busy_early", 64'(bus0.busy), 64'(0));
        @(posedge clk);
        #1 chk("busy_3clk", 64'(bus0.busy), 64'(1));
        repeat (4) @(posedge clk);
        #1 bus0.spin = 1'b0;
    endtask

    // Wait for HOLD, optionally poke spin inside it, and measure its length
    task automatic hold_phase0(input bit poke, output int dur);
        int c;
        c = 0;
        while (!bus0.result_valid && c < 8000) begin @(posedge clk); #1 c++; end
        if (c >= 8000) chk("rv_timeout", 64'(0), 64'(1));
        chk("locked_at_hold", 64'(bus0.locked), 64'(4'hF));
        dur = 0;
        while (bus0.result_valid && dur < 8000) begin
            @(posedge clk); #1 dur++;
            if (poke && dur == 1000) bus0.spin = 1'b1;
            if (poke && dur == 1010) bus0.spin = 1'b0;
        end
    endtask

    initial begin
        int dur, c, d0;
        logic [15:0] tgt, exp_d;
        bus0.spin = 1'b0;
        bus0.target = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_digit",  64'(bus0.digit),  64'(16'h9999));
        chk("rst_seg",    64'(bus0.seg),    64'({4{7'h6F}}));
        chk("rst_locked", 64'(bus0.locked), 64'(0));
        chk("rst_busy",   64'(bus0.busy),   64'(0));
        chk("rst_rv",     64'(bus0.result_valid), 64'(0));
        repeat (69) @(posedge clk);
        #1 chk("roll_pre_tick", 64'(bus0.digit), 64'(16'h9999));
        @(posedge clk);
        #1 chk("roll_1tick", 64'(bus0.digit), 64'(16'h8888));
        repeat (630) @(posedge clk);
        #1 chk("roll_10tick", 64'(bus0.digit), 64'(16'h9999));

        // Reels 0..3 target 1,5,7,0
        bus0.target = 16'h0751;
        press0();
        hold_phase0(1'b0, dur);
        chk("hold_len", 64'(dur), 64'(3500));
        chk("final_digit", 64'(bus0.digit), 64'(16'h0751));
        chk("idle_locked", 64'(bus0.locked), 64'(0));
        chk("idle_busy", 64'(bus0.busy), 64'(0));

        // Extra edges during SPIN and HOLD have no effect
        bus0.target = 16'h3928;
        press0();
        repeat (500) @(posedge clk);
        #1 bus0.spin = 1'b1;
        repeat (5) @(posedge clk);
        #1 bus0.spin = 1'b0;
        hold_phase0(1'b1, dur);
        chk("hold_len_pokes", 64'(dur), 64'(3500));
        chk("final_digit2", 64'(bus0.digit), 64'(16'h3928));
        chk("idle_busy2", 64'(bus0.busy), 64'(0));

        // New spin from IDLE, then reset while reels 0 and 1 are locked
        bus0.target = 16'h0000;
        press0();
        c = 0;
        while (bus0.locked[1:0] != 2'b11 && c < 8000) begin @(posedge clk); #1 c++; end
        chk("two_locked_reached", 64'(bus0.locked[3:2]), 64'(0));
        rst_n = 1'b0;
        #1 chk("midrst_digit", 64'(bus0.digit), 64'(16'h9999));
        chk("midrst_locked", 64'(bus0.locked), 64'(0));
        chk("midrst_busy", 64'(bus0.busy), 64'(0));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        c = 0;
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #1 if (bus0.busy) c++;
        end
        chk("no_spin_after_rst", 64'(c), 64'(0));

        // Reel 0 target equals its digit on the first SETTLE tick; reel 2 target 0xC
        @(posedge clk); #1 bus0.spin = 1'b1;
        c = 0;
        while (!bus0.busy && c < 20) begin @(posedge clk); #1 c++; end
        chk("busy_seen", 64'(bus0.busy), 64'(1));
        d0 = m_dig[0][0];
        bus0.target = {4'h2, 4'hC, 4'h4, 4'(d0)};
        bus0.spin = 1'b0;
        c = 0;
        while (m_ph[0] != P_SETTLE && c < 3000) begin @(posedge clk); #1 c++; end
        repeat (69) @(posedge clk);
        #1 chk("r0_not_yet", 64'(bus0.locked[0]), 64'(0));
        @(posedge clk);
        #1 chk("r0_first_tick", 64'(bus0.locked[0]), 64'(1));
        hold_phase0(1'b0, dur);
        chk("reel2_clamped", 64'(bus0.digit[11:8]), 64'(0));
        chk("final_digit4", 64'(bus0.digit), 64'({4'h2, 4'h0, 4'h4, 4'(d0)}));

        // Random targets including non-decimal codes
        for (int r = 0; r < 2; r++) begin
            tgt = 16'($urandom);
            bus0.target = tgt;
            repeat ($urandom_range(0, 69)) @(posedge clk);
            press0();
            hold_phase0(1'b0, dur);
            for (int k = 0; k < 4; k++)
                exp_d[4*k +: 4] = (tgt[4*k +: 4] > 4'd9) ? 4'd0 : tgt[4*k +: 4];
            chk("rand_hold_len", 64'(dur), 64'(3500));
            chk("rand_final", 64'(bus0.digit), 64'(exp_d));
        end

        done = 1'b1;
        repeat (20) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
